// File: rtl/us_timming_rr_reader.sv
// rtl/us_timming_rr_reader.sv - round-robin burst reader draining upstream timing caches
module us_timming_rr_reader #(
    parameter int TOTAL_NUM = 114,
    parameter int BURST_MAX = 16,
    parameter int CH_W      = 7
) (
    input  logic                     sys_clk_i,
    input  logic                     rst_i,
    input  logic                     enable_i,
    input  logic [TOTAL_NUM-1:0]     us_timming_empty_i,
    input  logic [TOTAL_NUM*12-1:0]  us_timming_cache_count_i,
    input  logic [TOTAL_NUM*128-1:0] us_timming_dout_i,
    output logic [TOTAL_NUM-1:0]     us_timming_rd_en_o,
    output logic                     m_valid_o,
    input  logic                     m_ready_i,
    output logic [127:0]             m_data_o,
    output logic                     m_last_o,
    output logic [CH_W-1:0]          m_ch_o,
    output logic                     busy_o
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;
    localparam logic [11:0] BURST_MAX_W = 12'(BURST_MAX);

    logic [1:0]      state;
    logic [CH_W-1:0] grant;
    logic [CH_W-1:0] last_grant;
    logic [11:0]     burst_len;
    logic [11:0]     issued;
    logic            inflight;
    logic            inflight_last;

    logic [127:0]    skid_data [2];
    logic [CH_W-1:0] skid_ch [2];
    logic [1:0]      skid_last;
    logic            rd_ptr;
    logic            wr_ptr;
    logic [1:0]      occ;

    logic [127:0]    dout_arr [TOTAL_NUM];
    logic [11:0]     count_arr [TOTAL_NUM];

    logic            pick_found;
    logic [CH_W-1:0] pick_idx;
    logic [11:0]     pick_count;
    logic [11:0]     pick_len;
    int              scan_sum;
    logic [CH_W-1:0] scan_idx;

    logic            issue;
    logic            bypass;
    logic            head_valid;
    logic            head_last;
    logic            pop;
    logic            push;
    logic            pop_mem;

    genvar g;
    generate
        for (g = 0; g < TOTAL_NUM; g++) begin : g_unpack
            assign dout_arr[g]  = us_timming_dout_i[g*128 +: 128];
            assign count_arr[g] = us_timming_cache_count_i[g*12 +: 12];
        end
    endgenerate

    // Round-robin search starting one past the previous winner.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_sum   = 0;
        scan_idx   = '0;
        for (int i = 0; i < TOTAL_NUM; i++) begin
            scan_sum = int'(last_grant) + 1 + i;
            if (scan_sum >= TOTAL_NUM) begin
                scan_sum = scan_sum - TOTAL_NUM;
            end
            scan_idx = CH_W'(scan_sum);
            if (!pick_found && !us_timming_empty_i[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        pick_count = count_arr[pick_idx];
        pick_len   = (pick_count > BURST_MAX_W) ? BURST_MAX_W : pick_count;
        if (pick_len == 12'd0) begin
            pick_len = 12'd1;
        end
    end

    // In-flight read counts against the two skid slots so nothing can overflow.
    assign issue = (state == ST_BURST) && !us_timming_empty_i[grant] &&
                   (issued < burst_len) && ((occ + {1'b0, inflight}) < 2'd2);

    always_comb begin
        us_timming_rd_en_o = '0;
        if (issue && !rst_i) begin
            us_timming_rd_en_o[grant] = 1'b1;
        end
    end

    // An empty skid presents the returning FIFO word directly.
    assign bypass     = (occ == 2'd0);
    assign head_valid = !bypass || inflight;
    assign head_last  = bypass ? inflight_last : skid_last[rd_ptr];
    assign pop        = head_valid && m_ready_i;
    assign push       = inflight && !(bypass && pop);
    assign pop_mem    = pop && !bypass;

    assign m_valid_o = head_valid;
    assign m_data_o  = !head_valid ? 128'd0 : (bypass ? dout_arr[grant] : skid_data[rd_ptr]);
    assign m_ch_o    = !head_valid ? '0 : (bypass ? grant : skid_ch[rd_ptr]);
    assign m_last_o  = head_valid && head_last;
    assign busy_o    = (state != ST_IDLE);

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            state         <= ST_IDLE;
            grant         <= '0;
            last_grant    <= CH_W'(TOTAL_NUM - 1);
            burst_len     <= 12'd0;
            issued        <= 12'd0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            occ           <= 2'd0;
            rd_ptr        <= 1'b0;
            wr_ptr        <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue && (issued == burst_len - 12'd1);
            if (issue) begin
                issued <= issued + 12'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (enable_i && !(&us_timming_empty_i)) begin
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (pick_found) begin
                        grant      <= pick_idx;
                        last_grant <= pick_idx;
                        burst_len  <= pick_len;
                        issued     <= 12'd0;
                        state      <= ST_BURST;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_BURST: begin
                    if (issue && (issued + 12'd1 == burst_len)) begin
                        state <= ST_DRAIN;
                    end
                end
                default: begin
                    if (pop && head_last) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop_mem) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, push} - {1'b0, pop_mem};
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (push) begin
            skid_data[wr_ptr] <= dout_arr[grant];
            skid_ch[wr_ptr]   <= grant;
            skid_last[wr_ptr] <= inflight_last;
        end
    end
endmodule

// File: tb/tb_us_timming_rr_reader.sv
// tb/tb_us_timming_rr_reader.sv - self-checking bench for us_timming_rr_reader
module tb_us_timming_rr_reader;
    localparam int TN = 114;
    localparam int BM = 16;
    localparam int CW = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic              ready;
    logic [TN-1:0]     empty;
    logic [TN*12-1:0]  count;
    logic [TN*128-1:0] dout;
    logic [TN-1:0]     rd_en;
    logic              m_valid;
    logic [127:0]      m_data;
    logic              m_last;
    logic [CW-1:0]     m_ch;
    logic              busy;

    us_timming_rr_reader #(.TOTAL_NUM(TN), .BURST_MAX(BM), .CH_W(CW)) dut (
        .sys_clk_i               (clk),
        .rst_i                   (rst),
        .enable_i                (enable),
        .us_timming_empty_i      (empty),
        .us_timming_cache_count_i(count),
        .us_timming_dout_i       (dout),
        .us_timming_rd_en_o      (rd_en),
        .m_valid_o               (m_valid),
        .m_ready_i               (ready),
        .m_data_o                (m_data),
        .m_last_o                (m_last),
        .m_ch_o                  (m_ch),
        .busy_o                  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] d;
        int           ch;
        logic         last;
    } word_t;

    typedef struct {
        int ch_a;
        int cnt_a;
        int ch_b;
        int cnt_b;
        int mode;
        int exp_words;
        int exp_bursts;
    } vec_t;

    logic [127:0] cache_q [TN][$];
    logic [127:0] tmp_q [TN][$];
    logic [TN-1:0] force_empty;
    word_t  expq[$];
    int     burst_ch[$];
    vec_t   tbl[6];

    int vectors = 0;
    int miscompares = 0;
    int seq = 0;
    int outstanding;
    int words_seen;
    int bursts_seen;
    logic prev_stall;
    logic [127:0] prev_data;
    logic [CW-1:0] prev_ch;
    logic prev_last;
    logic [TN-1:0] s_rd;
    logic s_valid, s_last, s_busy;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s", name);
    endtask

    task automatic refresh();
        for (int i = 0; i < TN; i++) begin
            empty[i] = (cache_q[i].size() == 0) || force_empty[i];
            count[i*12 +: 12] = 12'(cache_q[i].size());
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < TN; i++) cache_q[i].delete();
        force_empty = '0;
        dout = '0;
        refresh();
    endtask

    task automatic load(input int ch, input int n);
        for (int j = 0; j < n; j++) begin
            cache_q[ch].push_back({8'(ch), 24'(seq), $urandom(), $urandom(), $urandom()});
            seq++;
        end
    endtask

    // Reference: list every word in the order a round-robin burst reader must emit it.
    task automatic build_expected();
        int lg;
        int c;
        int n;
        bit found;
        word_t w;
        expq.delete();
        for (int i = 0; i < TN; i++) tmp_q[i] = cache_q[i];
        lg = TN - 1;
        while (1) begin
            found = 0;
            c = 0;
            for (int k = 1; k <= TN && !found; k++) begin
                c = (lg + k) % TN;
                if (tmp_q[c].size() > 0) found = 1;
            end
            if (!found) break;
            n = tmp_q[c].size();
            if (n > BM) n = BM;
            for (int j = 0; j < n; j++) begin
                w.d = tmp_q[c].pop_front();
                w.ch = c;
                w.last = (j == n - 1);
                expq.push_back(w);
            end
            lg = c;
        end
    endtask

    task automatic sample();
        logic xfer;
        int idx;
        word_t w;
        s_rd = rd_en;
        s_valid = m_valid;
        s_last = m_last;
        s_busy = busy;
        if (rst) begin
            chk("rd_en_during_reset", rd_en, 0);
            outstanding = 0;
            prev_stall = 0;
            return;
        end
        if (rd_en != '0) begin
            idx = 0;
            for (int i = 0; i < TN; i++) if (rd_en[i]) idx = i;
            chk("rd_en_onehot", $onehot(rd_en), 1);
            chk("rd_en_target_nonempty", (cache_q[idx].size() > 0) && !force_empty[idx], 1);
            chk("outstanding_le_2", (outstanding + 1) <= 2, 1);
        end
        if (prev_stall) begin
            chk("stall_valid", m_valid, 1);
            chk("stall_data", m_data, prev_data);
            chk("stall_ch", m_ch, prev_ch);
            chk("stall_last", m_last, prev_last);
        end
        xfer = m_valid && ready;
        if (xfer) begin
            if (expq.size() == 0) begin
                fail("unexpected_extra_word");
            end else begin
                w = expq.pop_front();
                chk("word_data", m_data, w.d);
                chk("word_ch", m_ch, w.ch);
                chk("word_last", m_last, w.last);
            end
            words_seen++;
            if (m_last) begin
                bursts_seen++;
                burst_ch.push_back(int'(m_ch));
            end
        end
        outstanding = outstanding + int'(rd_en != '0) - int'(xfer);
        prev_stall = m_valid && !ready;
        prev_data = m_data;
        prev_ch = m_ch;
        prev_last = m_last;
    endtask

    task automatic env_update();
        for (int i = 0; i < TN; i++) begin
            if (s_rd[i] && cache_q[i].size() > 0) dout[i*128 +: 128] = cache_q[i].pop_front();
        end
        refresh();
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        env_update();
    endtask

    task automatic clear_score();
        outstanding = 0;
        prev_stall = 0;
        words_seen = 0;
        bursts_seen = 0;
        burst_ch.delete();
    endtask

    task automatic do_reset();
        rst = 1;
        enable = 0;
        ready = 0;
        step();
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_ch", m_ch, 0);
        chk("rst_busy", busy, 0);
        rst = 0;
        clear_score();
        expq.delete();
    endtask

    task automatic run_until_done(input int budget, input int mode, input bit rand_en);
        int cyc;
        cyc = 0;
        do begin
            if (mode == 0) ready = 1;
            else if (mode == 1) ready = ~ready;
            else ready = ($urandom_range(0, 3) != 0);
            if (rand_en) enable = ($urandom_range(0, 7) != 0);
            step();
            cyc++;
        end while (cyc < budget && !(expq.size() == 0 && !s_busy));
        if (!(expq.size() == 0 && !s_busy)) fail("run_timeout");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pat_rd[7];
        int pat_v[7];
        int pat_l[7];
        int pat_b[7];
        int order[6];
        int rd7;
        int cyc;
        int bad;

        rst = 1;
        enable = 0;
        ready = 0;
        force_empty = '0;
        empty = '1;
        count = '0;
        dout = '0;
        clear_score();

        tbl[0] = '{ch_a: 5,  cnt_a: 3,   ch_b: 0,   cnt_b: 0,  mode: 0, exp_words: 3,   exp_bursts: 1};
        tbl[1] = '{ch_a: 0,  cnt_a: 40,  ch_b: 113, cnt_b: 40, mode: 0, exp_words: 80,  exp_bursts: 6};
        tbl[2] = '{ch_a: 10, cnt_a: 4,   ch_b: 0,   cnt_b: 0,  mode: 1, exp_words: 4,   exp_bursts: 1};
        tbl[3] = '{ch_a: 20, cnt_a: 16,  ch_b: 21,  cnt_b: 17, mode: 2, exp_words: 33,  exp_bursts: 3};
        tbl[4] = '{ch_a: 113, cnt_a: 1,  ch_b: 0,   cnt_b: 0,  mode: 1, exp_words: 1,   exp_bursts: 1};
        tbl[5] = '{ch_a: 3,  cnt_a: 100, ch_b: 60,  cnt_b: 5,  mode: 2, exp_words: 105, exp_bursts: 8};
        order = '{0, 113, 0, 113, 0, 113};

        for (int t = 0; t < 6; t++) begin
            clear_all();
            do_reset();
            load(tbl[t].ch_a, tbl[t].cnt_a);
            load(tbl[t].ch_b, tbl[t].cnt_b);
            refresh();
            build_expected();
            enable = 1;
            ready = 1;
            run_until_done(3000, tbl[t].mode, 0);
            chk("tbl_words", words_seen, tbl[t].exp_words);
            chk("tbl_bursts", bursts_seen, tbl[t].exp_bursts);
            if (t == 1) begin
                for (int k = 0; k < 6; k++)
                    chk("wrap_order", (burst_ch.size() > k) ? burst_ch[k] : -1, order[k]);
            end
        end

        // Start latency and back-to-back issue for a 3-word burst.
        pat_rd = '{0, 0, 1, 1, 1, 0, 0};
        pat_v  = '{0, 0, 0, 1, 1, 1, 0};
        pat_l  = '{0, 0, 0, 0, 0, 1, 0};
        pat_b  = '{0, 1, 1, 1, 1, 1, 0};
        clear_all();
        do_reset();
        load(5, 3);
        refresh();
        build_expected();
        enable = 1;
        ready = 1;
        for (int c = 0; c < 7; c++) begin
            step();
            chk("lat_rd_en5", s_rd[5], pat_rd[c]);
            chk("lat_valid", s_valid, pat_v[c]);
            chk("lat_last", s_last, pat_l[c]);
            chk("lat_busy", s_busy, pat_b[c]);
        end
        chk("lat_words", words_seen, 3);

        // Empty flag glitch mid-burst stalls issue without truncating.
        clear_all();
        do_reset();
        load(7, 6);
        refresh();
        build_expected();
        enable = 1;
        ready = 1;
        rd7 = 0;
        cyc = 0;
        while (rd7 < 2 && cyc < 20) begin
            step();
            if (s_rd[7]) rd7++;
            cyc++;
        end
        chk("stall_reads_before", rd7, 2);
        force_empty[7] = 1'b1;
        refresh();
        for (int c = 0; c < 5; c++) begin
            step();
            chk("stall_rd_low", s_rd, 0);
        end
        force_empty[7] = 1'b0;
        refresh();
        run_until_done(200, 0, 0);
        chk("stall_words", words_seen, 6);
        chk("stall_bursts", bursts_seen, 1);

        // Reset pulse mid-burst discards the burst.
        clear_all();
        do_reset();
        load(2, 8);
        load(9, 5);
        refresh();
        build_expected();
        enable = 1;
        ready = 1;
        cyc = 0;
        while (words_seen < 3 && cyc < 30) begin
            step();
            cyc++;
        end
        chk("mid_reset_words_before", words_seen, 3);
        rst = 1;
        step();
        chk("mid_reset_rd_low", s_rd, 0);
        rst = 0;
        clear_score();
        build_expected();
        step();
        chk("mid_reset_valid_after", s_valid, 0);
        run_until_done(300, 0, 0);
        chk("mid_reset_first_ch", (burst_ch.size() > 0) ? burst_ch[0] : -1, 2);
        chk("mid_reset_bursts", bursts_seen, 2);

        // enable_i gating at IDLE and not mid-burst.
        clear_all();
        do_reset();
        load(30, 20);
        load(31, 3);
        refresh();
        build_expected();
        enable = 0;
        ready = 1;
        bad = 0;
        repeat (100) begin
            step();
            if (s_busy || s_rd != '0) bad++;
        end
        chk("disabled_idle_cycles", bad, 0);
        enable = 1;
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (s_rd == '0 && cyc < 10);
        chk("enable_start_rd", s_rd[30], 1);
        enable = 0;
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!(words_seen == 16 && !s_busy) && cyc < 80);
        chk("disable_burst_words", words_seen, 16);
        chk("disable_burst_idle", s_busy, 0);
        bad = 0;
        repeat (20) begin
            step();
            if (s_busy || s_rd != '0) bad++;
        end
        chk("stays_idle_after_disable", bad, 0);
        enable = 1;
        run_until_done(500, 0, 0);
        chk("resume_words", words_seen, 23);

        // Randomized cache contents, back-pressure and enable.
        for (int r = 0; r < 6; r++) begin
            int nch;
            int total;
            clear_all();
            do_reset();
            total = 0;
            nch = $urandom_range(1, 5);
            for (int k = 0; k < nch; k++) begin
                int c;
                int n;
                c = $urandom_range(0, TN - 1);
                n = $urandom_range(1, 40);
                load(c, n);
                total += n;
            end
            refresh();
            build_expected();
            enable = 1;
            run_until_done(6000, 2, 1);
            chk("rand_words", words_seen, total);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
